csa_resolver: RTL and testbench
===============================

# csa_resolver

Converts a carry-save operand pair (sum vector, carry vector) into a plain binary result, one CHUNK-bit slice per cycle. It is the consumer end of the carry-save arithmetic path: carry-save compressor trees hand it their redundant output, and it performs the final carry-propagate addition. A valid/ready handshake sits on both sides. Splitting the addition into slices keeps the critical path to one CHUNK-bit ripple, at the cost of several cycles per operation.

## Interface
Parameters:
- N, default 8: width of the carry-save vectors.
- CHUNK, default 4: bits resolved per cycle; legal range 1..N+2.
- Derived W = N+2: result width. NUM_CHUNKS = ceil(W/CHUNK).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  carry-save pair presented.
- in_ready  out  1  block can accept a pair.
- in_sum  in  N  sum vector, weight 2^i per bit i.
- in_carry  in  N  carry vector, weight 2^(i+1) per bit i.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  W  result = in_sum + (in_carry << 1).

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. When in_valid=1, the block captures both operands, zero-extended to W bits (carry already shifted left by 1). It clears the slice index and the carry flop, then moves to ADD.
- ADD: in_ready=0. Each cycle adds slice k of both operands plus the carry flop, writes CHUNK result bits into slice k, updates the carry flop, and increments k.
  - The last slice may be partial; bits above W are ignored.
  - After slice NUM_CHUNKS-1 the FSM moves to DONE.
- DONE: out_valid=1 and out_result is stable. It holds until out_ready=1, then returns to IDLE.
- Width rule: the maximum result is 3·(2^N−1), which always fits in W bits. The final carry-out is discarded and is always 0.
- out_result holds its last value outside DONE. Only values read while out_valid=1 are meaningful.
- Reset values: in_ready=1, out_valid=0, out_result=0, state=IDLE, internal carry=0, slice index=0.
- Reset mid-operation: the block aborts immediately and returns to the reset values. No output is produced for the aborted pair.
- A pair is accepted only in IDLE. Input changes while in_ready=0 are ignored.

## Timing
- Accept handshake at edge T0. Slices are processed at edges T1..T_NUM_CHUNKS. out_valid goes high after edge T_NUM_CHUNKS.
- Latency from accept to out_valid is NUM_CHUNKS cycles. With N=8, CHUNK=4: 3 cycles.
- If out_ready=1 while out_valid=1, the output handshake completes at that edge. in_ready rises in the following cycle (DONE→IDLE), so there is no same-cycle pass-through.
- Throughput is one result per NUM_CHUNKS+2 cycles with no backpressure.
- Backpressure in DONE has no bound. The result and state are held.

## Configuration
- Macro CSA_RESOLVER_OVF_EN.
  - Defined: adds output port out_ovf (out, 1). It is 1 when out_result[W-1:N] != 0, i.e. the result does not fit in N bits. It is valid with out_valid, registered together with the last slice, and resets to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package csa_resolver_pkg holds:
  - the state enum (IDLE, ADD, DONE);
  - a num_chunks(W, CHUNK) constant function;
  - the encoding widths for the slice index.
- One sub-module, csa_chunk_adder: a CHUNK-bit combinational adder with cin/cout, instantiated once and muxed by the slice index.

## Test plan
All scenarios use N=8, CHUNK=4 unless noted.
- Zero: sum=0x00, carry=0x00 → out_result=0x000 after 3 cycles; out_ovf=0.
- Max: sum=0xFF, carry=0xFF → out_result=0x2FD; out_ovf=1.
- Interleaved: sum=0x55, carry=0xAA → 0x1A9. Then sum=0x01, carry=0x00 → 0x001 with out_ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_result stays stable and in_ready stays 0. Toggle in_sum/in_carry meanwhile; the result must be unaffected. Release out_ready → IDLE on the next cycle.
- Reset mid-ADD: assert rst after slice 1 → out_valid=0, in_ready=1 immediately. A new pair sum=0x10, carry=0x08 → 0x020.
- CHUNK=10 (single slice): sum=0xFF, carry=0x01 → out_result=0x101 with 1-cycle latency.

Source files
------------

// File: rtl/csa_resolver_pkg.sv
// Shared types and constant helpers for the carry-save resolver.
// Optional feature macro: CSA_RESOLVER_OVF_EN (adds the out_ovf output).
package csa_resolver_pkg;

    // Controller states: wait for a pair, resolve slices, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of CHUNK-bit slices needed to cover a w-bit result
    function automatic int num_chunks(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

    // Width of the slice index register; at least one bit even for a single slice
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit combinational ripple adder with carry in and carry out.
module csa_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    // One slice of the final carry-propagate addition
    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (CHUNK + 1)'(cin_i);
    end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (sum, carry) into a binary result, CHUNK bits per cycle.
// Optional feature macro: CSA_RESOLVER_OVF_EN adds out_ovf, set when the result
// does not fit in N bits.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic [N-1:0]     in_carry,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_RESOLVER_OVF_EN
    output logic             out_ovf,
`endif
    output logic [N+1:0]     out_result
);

    localparam int W  = N + 2;
    localparam int NC = num_chunks(W, CHUNK);
    localparam int IW = idx_bits(NC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   k_q, k_d;
    logic [CHUNK-1:0] a_slice, b_slice, slice_sum;
    logic            slice_cout;
    logic            last_slice;
`ifdef CSA_RESOLVER_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    // Select slice k of both operands; bits past the top of the operand read as zero
    assign a_slice    = CHUNK'(a_q >> (int'(k_q) * CHUNK));
    assign b_slice    = CHUNK'(b_q >> (int'(k_q) * CHUNK));
    assign last_slice = (k_q == LAST_IDX);

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_slice),
        .b_i    (b_slice),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // State register and datapath registers, cleared on reset
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
`ifdef CSA_RESOLVER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            k_q     <= k_d;
`ifdef CSA_RESOLVER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, walk the slices, hold in DONE until taken
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)              state_d = ADD;
            ADD:  if (last_slice)            state_d = DONE;
            DONE: if (out_ready)             state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: capture operands, then write one result slice per ADD cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        k_d     = k_q;
`ifdef CSA_RESOLVER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Zero-extend sum; carry carries weight 2^(i+1), so it lands one bit up
                    a_d          = '0;
                    a_d[N-1:0]   = in_sum;
                    b_d          = '0;
                    b_d[N:1]     = in_carry;
                    carry_d      = 1'b0;
                    k_d          = '0;
                end
            end
            ADD: begin
                // Bits of a partial last slice above W have no home and are dropped
                for (int i = 0; i < W; i++) begin
                    if ((i / CHUNK) == int'(k_q)) begin
                        res_d[i] = slice_sum[i % CHUNK];
                    end
                end
                // The final carry-out is always zero because 3*(2^N-1) fits in W bits
                carry_d = slice_cout;
                k_d     = k_q + IW'(1);
`ifdef CSA_RESOLVER_OVF_EN
                if (last_slice) begin
                    ovf_d = |res_d[W-1:N];
                end
`endif
            end
            default: ;
        endcase
    end

    assign out_result = res_q;
`ifdef CSA_RESOLVER_OVF_EN
    assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: N=8 with CHUNK=4, plus a CHUNK=10 single-slice instance.
// Optional feature macro: CSA_RESOLVER_OVF_EN (out_ovf is connected and checked when defined).
module tb_csa_resolver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // CHUNK=4 instance
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_sum, in_carry;
    logic [9:0] out_result;
    // CHUNK=10 instance
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_sum, b_in_carry;
    logic [9:0] b_out_result;
`ifdef CSA_RESOLVER_OVF_EN
    logic       out_ovf, b_out_ovf;
`endif

    csa_resolver #(.N(8), .CHUNK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef CSA_RESOLVER_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .out_result (out_result)
    );

    csa_resolver #(.N(8), .CHUNK(10)) dut10 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_sum     (b_in_sum),
        .in_carry   (b_in_carry),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
`ifdef CSA_RESOLVER_OVF_EN
        .out_ovf    (b_out_ovf),
`endif
        .out_result (b_out_result)
    );

    typedef struct packed {
        logic [9:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb10_q[$];
    exp_t mon_e, mon10_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a result is consumed on the edge after a negedge that sees valid && ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", 32'(out_result), 32'(mon_e.res));
`ifdef CSA_RESOLVER_OVF_EN
                check("ovf", 32'(out_ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (sb10_q.size() == 0) begin
                check("unexpected_result10", 32'(sb10_q.size()), 32'd1);
            end else begin
                mon10_e = sb10_q.pop_front();
                check("result10", 32'(b_out_result), 32'(mon10_e.res));
`ifdef CSA_RESOLVER_OVF_EN
                check("ovf10", 32'(b_out_ovf), 32'(mon10_e.ovf));
`endif
            end
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] c,
                        input logic [9:0] r, input logic o, input bit push);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        if (push) sb_q.push_back('{res: r, ovf: o});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat, input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sum      = '0;
        in_carry    = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_sum    = '0;
        b_in_carry  = '0;
        b_out_ready = 1'b1;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", 32'(out_result), 32'd0);
        rst = 1'b0;
        tick();

        // Zero operands, with latency and no pass-through checks
        send(8'h00, 8'h00, 10'h000, 1'b0, 1'b1);
        wait_valid(3, "latency_zero");
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_after_take", 32'(in_ready), 32'd1);

        // Largest result
        send(8'hFF, 8'hFF, 10'h2FD, 1'b1, 1'b1);
        wait_valid(3, "latency_max");
        tick();

        // Interleaved bit patterns, then a small value
        send(8'h55, 8'hAA, 10'h1A9, 1'b1, 1'b1);
        wait_valid(3, "latency_interleave");
        tick();
        send(8'h01, 8'h00, 10'h001, 1'b0, 1'b1);
        wait_valid(3, "latency_small");
        tick();

        // Backpressure: result held for 10 cycles while inputs churn
        out_ready = 1'b0;
        send(8'h3C, 8'h0F, 10'h05A, 1'b0, 1'b1);
        wait_valid(3, "latency_bp");
        for (int i = 0; i < 10; i++) begin
            in_sum   = 8'($urandom);
            in_carry = 8'($urandom);
            in_valid = 1'b1;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result_stable", 32'(out_result), 32'h05A);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset after slice 1: the aborted pair produces nothing
        send(8'h77, 8'h11, 10'h099, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_result", 32'(out_result), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(8'h10, 8'h08, 10'h020, 1'b0, 1'b1);
        wait_valid(3, "latency_after_reset");
        tick();

        // Single-slice instance: one cycle of latency
        begin
            int n = 0;
            check("c10_in_ready", 32'(b_in_ready), 32'd1);
            b_in_sum   = 8'hFF;
            b_in_carry = 8'h01;
            b_in_valid = 1'b1;
            sb10_q.push_back('{res: 10'h101, ovf: 1'b1});
            tick();
            b_in_valid = 1'b0;
            while (!b_out_valid && n < 50) begin
                tick();
                n++;
            end
            check("latency_c10", 32'(n), 32'd1);
            tick();
        end

        // Drain: every expected result must have been seen
        for (int i = 0; i < 20 && (sb_q.size() != 0 || sb10_q.size() != 0); i++) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("sb10_drained", 32'(sb10_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
